// File: rtl/isp_pkg.sv
// Shared definitions for the ISP test-pattern source: FSM encoding, pattern
// codes and the colour-bar palette.
package isp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_V_FRONT = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_V_BACK  = 2'd3
  } state_t;

  localparam logic [2:0] PAT_BARS  = 3'd0;
  localparam logic [2:0] PAT_GRAD  = 3'd1;
  localparam logic [2:0] PAT_CHECK = 3'd2;
  localparam logic [2:0] PAT_GREY  = 3'd3;
  localparam logic [2:0] PAT_TINT  = 3'd4;

  localparam int unsigned NUM_BARS = 8;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Index 0 (rightmost) is the first bar on the left of the screen
  localparam rgb_t [7:0] BAR_TABLE = {
    24'h000000,  // black
    24'h0000FF,  // blue
    24'hFF0000,  // red
    24'hFF00FF,  // magenta
    24'h00FF00,  // green
    24'h00FFFF,  // cyan
    24'hFFFF00,  // yellow
    24'hFFFFFF   // white
  };

endpackage

// File: rtl/isp_pattern_pix.sv
// Combinational pixel colour lookup: (x, y, pattern, bar index) -> RGB.
module isp_pattern_pix
  import isp_pkg::*;
(
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [2:0] sel,
  input  logic [2:0] bar_idx,
  output rgb_t       rgb_c
);

  always_comb begin
    rgb_c = '0;
    case (sel)
      PAT_BARS:  rgb_c = BAR_TABLE[bar_idx];
      PAT_GRAD: begin
        rgb_c.r = x;
        rgb_c.g = y;
        rgb_c.b = 8'(x + y);
      end
      PAT_CHECK: if (x[5] ^ y[5]) rgb_c = '1;
      PAT_GREY:  rgb_c = '{r: 8'h80, g: 8'h80, b: 8'h80};
      PAT_TINT:  rgb_c = '{r: 8'h40, g: 8'h80, b: 8'hC0};
      default:   rgb_c = '0;
    endcase
  end

endmodule

// File: rtl/isp_pattern_gen.sv
// ISP test-pattern video source: frame timing FSM, counters and registered outputs.
// Optional horizontal scrolling of patterns 0-2 with `define ISP_PATGEN_MOVING_EN.
module isp_pattern_gen
  import isp_pkg::*;
#(
  parameter int unsigned source_h = 512,
  parameter int unsigned source_v = 512,
  parameter int unsigned h_blank  = 64,
  parameter int unsigned v_front  = 4,
  parameter int unsigned v_back   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] pattern_sel,
  output logic       out_vsync,
  output logic       out_hsync,
  output logic       out_den,
  output logic [7:0] out_data_R,
  output logic [7:0] out_data_G,
  output logic [7:0] out_data_B,
  output logic       frame_done
);

  localparam int unsigned H_TOTAL = source_h + h_blank;
  localparam int unsigned H_W     = $clog2(H_TOTAL);
  localparam int unsigned V_MAX   = (v_front > source_v) ?
                                    ((v_front > v_back) ? v_front : v_back) :
                                    ((source_v > v_back) ? source_v : v_back);
  localparam int unsigned V_W     = $clog2(V_MAX + 1);
  localparam int unsigned BAR_W   = source_h / NUM_BARS;

  // Horizontal pixel position tracked incrementally with its bar index/offset
  typedef struct packed {
    logic [H_W-1:0] x;
    logic [2:0]     bar;
    logic [H_W-1:0] pos;
  } xpos_t;

  function automatic xpos_t xpos_step(input xpos_t p);
    xpos_t n;
    n = p;
    if (p.x == H_W'(source_h - 1)) begin
      n = '0;
    end else begin
      n.x = H_W'(p.x + H_W'(1));
      if ((p.bar != 3'd7) && (p.pos == H_W'(BAR_W - 1))) begin
        n.bar = p.bar + 3'd1;
        n.pos = '0;
      end else begin
        n.pos = H_W'(p.pos + H_W'(1));
      end
    end
    return n;
  endfunction

  state_t         state, state_nxt;
  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic [V_W-1:0] v_last_c;
  logic           line_end_c, seg_end_c;
  logic           active_pix_c, frame_end_c, latch_sel_c;
  logic [2:0]     sel_q;
  xpos_t          xp, xp_start;
  rgb_t           pix_rgb_c;

  assign line_end_c = (h_cnt == H_W'(H_TOTAL - 1));
  assign seg_end_c  = line_end_c && (v_cnt == v_last_c);

  always_comb begin
    v_last_c = V_W'(v_front - 1);
    case (state)
      ST_ACTIVE: v_last_c = V_W'(source_v - 1);
      ST_V_BACK: v_last_c = V_W'(v_back - 1);
      default:   v_last_c = V_W'(v_front - 1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (enable)    state_nxt = ST_V_FRONT;
      ST_V_FRONT: if (seg_end_c) state_nxt = ST_ACTIVE;
      ST_ACTIVE:  if (seg_end_c) state_nxt = ST_V_BACK;
      ST_V_BACK:  if (seg_end_c) state_nxt = enable ? ST_V_FRONT : ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    active_pix_c = (state == ST_ACTIVE) && (h_cnt < H_W'(source_h));
    frame_end_c  = (state == ST_V_BACK) && seg_end_c;
    latch_sel_c  = enable && ((state == ST_IDLE) || frame_end_c);
  end

  // Line/position counters; v_cnt restarts in every FSM state
  always_ff @(posedge clk) begin
    if (reset || (state == ST_IDLE)) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= line_end_c ? '0 : H_W'(h_cnt + H_W'(1));
      if (state_nxt != state) v_cnt <= '0;
      else if (line_end_c)    v_cnt <= V_W'(v_cnt + V_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset)            sel_q <= '0;
    else if (latch_sel_c) sel_q <= pattern_sel;
  end

  always_ff @(posedge clk) begin
    if (reset)                                   xp <= '0;
    else if ((state == ST_IDLE) || line_end_c)   xp <= xp_start;
    else if (h_cnt < H_W'(source_h))             xp <= xpos_step(xp);
  end

`ifdef ISP_PATGEN_MOVING_EN
  logic [7:0] frame_cnt;

  // Line start position follows frame_cnt mod source_h, including the 8-bit wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      xp_start  <= '0;
    end else if (frame_done) begin
      frame_cnt <= frame_cnt + 8'd1;
      xp_start  <= (frame_cnt == 8'hFF) ? '0 : xpos_step(xp_start);
    end
  end
`else
  assign xp_start = '0;
`endif

  isp_pattern_pix u_pix (
    .x       (8'(xp.x)),
    .y       (8'(v_cnt)),
    .sel     (sel_q),
    .bar_idx (xp.bar),
    .rgb_c   (pix_rgb_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_vsync  <= 1'b0;
      out_hsync  <= 1'b0;
      out_den    <= 1'b0;
      out_data_R <= '0;
      out_data_G <= '0;
      out_data_B <= '0;
      frame_done <= 1'b0;
    end else begin
      out_vsync  <= (state == ST_ACTIVE);
      out_hsync  <= active_pix_c;
      out_den    <= active_pix_c;
      out_data_R <= active_pix_c ? pix_rgb_c.r : 8'h00;
      out_data_G <= active_pix_c ? pix_rgb_c.g : 8'h00;
      out_data_B <= active_pix_c ? pix_rgb_c.b : 8'h00;
      frame_done <= frame_end_c;
    end
  end

endmodule
